// File: rtl/hwpe_multistream_ctrl_fsm.sv
// HWPE control FSM for N_IN source and N_OUT sink streams: handshakes the streamer,
// drives the engine, tracks per-output completion and walks tiles through the uloop.
module hwpe_multistream_ctrl_fsm #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned N_OUT  = 1,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned TILE_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   start_i,
   input  logic [N_IN-1:0]        src_ready_start_i,
   input  logic [N_OUT-1:0]       snk_ready_start_i,
   output logic [N_IN-1:0]        src_req_start_o,
   output logic [N_OUT-1:0]       snk_req_start_o,
   output logic                   eng_start_o,
   output logic                   eng_clear_o,
   output logic                   eng_enable_o,
   input  logic                   eng_ready_i,
   input  logic [N_OUT*CNT_W-1:0] cnt_out_i,
   input  logic [N_OUT*CNT_W-1:0] cnt_limit_i,
   output logic                   uloop_enable_o,
   output logic                   uloop_clear_o,
   input  logic                   uloop_valid_i,
   input  logic                   uloop_done_i,
   output logic                   done_o,
   output logic                   busy_o,
   output logic [TILE_W-1:0]      tile_cnt_o,
   output logic [2:0]             state_o
);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StWaitRdy   = 3'd1,
      StCompute   = 3'd2,
      StDrain     = 3'd3,
      StUpdateIdx = 3'd4,
      StTerminate = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
   logic [N_OUT-1:0]  out_done_q, out_done_d;

   logic              all_rdy;
   logic [N_OUT-1:0]  limit_zero;
   logic [N_OUT-1:0]  cnt_hit;

   assign all_rdy = (&src_ready_start_i) & (&snk_ready_start_i);

   always_comb begin
      limit_zero = '0;
      cnt_hit    = '0;
      for (int k = 0; k < N_OUT; k++) begin
         limit_zero[k] = (cnt_limit_i[k*CNT_W +: CNT_W] == '0);
         cnt_hit[k]    = (cnt_out_i[k*CNT_W +: CNT_W] == cnt_limit_i[k*CNT_W +: CNT_W]);
      end
   end

   always_comb begin
      state_d         = state_q;
      tile_cnt_d      = tile_cnt_q;
      out_done_d      = out_done_q;
      src_req_start_o = '0;
      snk_req_start_o = '0;
      eng_start_o     = 1'b0;
      eng_clear_o     = 1'b1;
      eng_enable_o    = 1'b1;
      uloop_enable_o  = 1'b0;
      uloop_clear_o   = 1'b0;
      done_o          = 1'b0;

      if (clear_i) begin
         // Clear wins over everything; outputs stay at their idle defaults this cycle.
         state_d    = StIdle;
         tile_cnt_d = '0;
         out_done_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               uloop_clear_o = 1'b1;
               if (start_i) begin
                  state_d    = StWaitRdy;
                  tile_cnt_d = '0;
                  out_done_d = limit_zero;
               end
            end

            StWaitRdy: begin
               eng_clear_o  = 1'b0;
               eng_enable_o = 1'b0;
               if (all_rdy) begin
                  src_req_start_o = '1;
                  snk_req_start_o = '1;
                  eng_start_o     = 1'b1;
                  eng_enable_o    = 1'b1;
                  state_d         = StCompute;
               end
            end

            StCompute: begin
               eng_clear_o  = 1'b0;
               eng_enable_o = 1'b1;
               eng_start_o  = eng_ready_i;
               out_done_d   = out_done_q | cnt_hit;
               if (&out_done_d) begin
                  state_d = StDrain;
               end
            end

            StDrain: begin
               eng_clear_o  = 1'b0;
               eng_enable_o = 1'b0;
               if (all_rdy) begin
                  state_d    = StUpdateIdx;
                  tile_cnt_d = tile_cnt_q + 1'b1;
               end
            end

            StUpdateIdx: begin
               eng_clear_o    = 1'b0;
               eng_enable_o   = 1'b0;
               uloop_enable_o = ~uloop_valid_i;
               if (uloop_valid_i) begin
                  if (uloop_done_i) begin
                     state_d = StTerminate;
                  end else begin
                     // Next tile: restart completion tracking and zero the engine counters.
                     state_d     = StWaitRdy;
                     out_done_d  = limit_zero;
                     eng_clear_o = 1'b1;
                  end
               end
            end

            StTerminate: begin
               done_o  = 1'b1;
               state_d = StIdle;
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         tile_cnt_q <= '0;
         out_done_q <= '0;
      end else begin
         state_q    <= state_d;
         tile_cnt_q <= tile_cnt_d;
         out_done_q <= out_done_d;
      end
   end

   assign busy_o     = (state_q != StIdle);
   assign tile_cnt_o = tile_cnt_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_hwpe_multistream_ctrl_fsm.sv
// Self-checking bench for hwpe_multistream_ctrl_fsm (N_IN=2, N_OUT=2); completed jobs are
// scoreboarded against the tile count expected when each job was launched.
module tb_hwpe_multistream_ctrl_fsm;

   localparam int unsigned N_IN   = 2;
   localparam int unsigned N_OUT  = 2;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned TILE_W = 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_COMP = 3'd2;
   localparam logic [2:0] S_DRAN = 3'd3;
   localparam logic [2:0] S_UPD  = 3'd4;
   localparam logic [2:0] S_TERM = 3'd5;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic                   clear_i;
   logic                   start_i;
   logic [N_IN-1:0]        src_ready_start_i;
   logic [N_OUT-1:0]       snk_ready_start_i;
   logic [N_IN-1:0]        src_req_start_o;
   logic [N_OUT-1:0]       snk_req_start_o;
   logic                   eng_start_o;
   logic                   eng_clear_o;
   logic                   eng_enable_o;
   logic                   eng_ready_i;
   logic [N_OUT*CNT_W-1:0] cnt_out_i;
   logic [N_OUT*CNT_W-1:0] cnt_limit_i;
   logic                   uloop_enable_o;
   logic                   uloop_clear_o;
   logic                   uloop_valid_i;
   logic                   uloop_done_i;
   logic                   done_o;
   logic                   busy_o;
   logic [TILE_W-1:0]      tile_cnt_o;
   logic [2:0]             state_o;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int exp_q[$];

   always #5 clk_i = ~clk_i;

   hwpe_multistream_ctrl_fsm #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .CNT_W  (CNT_W),
      .TILE_W (TILE_W)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .clear_i           (clear_i),
      .start_i           (start_i),
      .src_ready_start_i (src_ready_start_i),
      .snk_ready_start_i (snk_ready_start_i),
      .src_req_start_o   (src_req_start_o),
      .snk_req_start_o   (snk_req_start_o),
      .eng_start_o       (eng_start_o),
      .eng_clear_o       (eng_clear_o),
      .eng_enable_o      (eng_enable_o),
      .eng_ready_i       (eng_ready_i),
      .cnt_out_i         (cnt_out_i),
      .cnt_limit_i       (cnt_limit_i),
      .uloop_enable_o    (uloop_enable_o),
      .uloop_clear_o     (uloop_clear_o),
      .uloop_valid_i     (uloop_valid_i),
      .uloop_done_i      (uloop_done_i),
      .done_o            (done_o),
      .busy_o            (busy_o),
      .tile_cnt_o        (tile_cnt_o),
      .state_o           (state_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every done pulse must match a job the stimulus launched, with its tile count.
   always @(negedge clk_i) begin
      if (rst_ni && done_o) begin
         done_cnt++;
         if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
         else check("tile_at_done", 32'(tile_cnt_o), 32'(exp_q.pop_front()));
      end
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_ch(input int k, input int v);
      cnt_out_i[k*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      int n = 0;
      while (state_o !== s && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(state_o), 32'(s));
   endtask

   // start pulse in IDLE, then WAIT_RDY with all flags ready, ending in the first COMPUTE cycle
   task automatic start_job();
      start_i = 1'b1;
      settle();
      step();
      start_i = 1'b0;
      settle();
      step();
   endtask

   task automatic count_ch1(input int lim);
      for (int v = 1; v <= lim; v++) begin
         set_ch(1, v);
         settle();
         check("in_compute", 32'(state_o), 32'(S_COMP));
         step();
      end
      check("to_drain", 32'(state_o), 32'(S_DRAN));
   endtask

   task automatic finish_tile(input bit last);
      wait_state("reach_drain", S_DRAN, 40);
      step();
      check("reach_upd", 32'(state_o), 32'(S_UPD));
      uloop_valid_i = 1'b1;
      uloop_done_i  = last;
      settle();
      check("uloop_en_valid", 32'(uloop_enable_o), 32'd0);
      step();
      uloop_valid_i = 1'b0;
      uloop_done_i  = 1'b0;
      cnt_out_i     = '0;
      settle();
   endtask

   initial begin
      rst_ni            = 1'b0;
      clear_i           = 1'b0;
      start_i           = 1'b0;
      src_ready_start_i = '1;
      snk_ready_start_i = '1;
      eng_ready_i       = 1'b1;
      cnt_out_i         = '0;
      cnt_limit_i       = '0;
      uloop_valid_i     = 1'b0;
      uloop_done_i      = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      settle();

      check("rst_state", 32'(state_o), 32'(S_IDLE));
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_tile", 32'(tile_cnt_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_uloop_clr", 32'(uloop_clear_o), 32'd1);
      check("rst_req", 32'({src_req_start_o, snk_req_start_o}), 32'd0);

      // Single output channel in use (ch1 limit 4), minimum latency, one tile
      cnt_limit_i = {16'd4, 16'd0};
      exp_q.push_back(1);
      start_i = 1'b1;
      settle();
      check("c0_state", 32'(state_o), 32'(S_IDLE));
      check("c0_busy", 32'(busy_o), 32'd0);
      step();
      start_i = 1'b0;
      settle();
      check("c1_state", 32'(state_o), 32'(S_WAIT));
      check("c1_busy", 32'(busy_o), 32'd1);
      check("c1_req", 32'({src_req_start_o, snk_req_start_o}), 32'hF);
      check("c1_eng_start", 32'(eng_start_o), 32'd1);
      check("c1_eng_en", 32'(eng_enable_o), 32'd1);
      check("c1_eng_clr", 32'(eng_clear_o), 32'd0);
      step();
      check("c2_state", 32'(state_o), 32'(S_COMP));
      check("c2_req", 32'({src_req_start_o, snk_req_start_o}), 32'd0);
      eng_ready_i = 1'b0;
      settle();
      check("eng_start_rdy0", 32'(eng_start_o), 32'd0);
      eng_ready_i = 1'b1;
      settle();
      check("eng_start_rdy1", 32'(eng_start_o), 32'd1);
      count_ch1(4);
      check("drain_eng_en", 32'(eng_enable_o), 32'd0);
      step();
      check("upd_state", 32'(state_o), 32'(S_UPD));
      check("upd_tile", 32'(tile_cnt_o), 32'd1);
      check("upd_uloop_en", 32'(uloop_enable_o), 32'd1);
      uloop_valid_i = 1'b1;
      uloop_done_i  = 1'b1;
      settle();
      check("upd_uloop_en_v", 32'(uloop_enable_o), 32'd0);
      step();
      uloop_valid_i = 1'b0;
      uloop_done_i  = 1'b0;
      cnt_out_i     = '0;
      settle();
      check("term_state", 32'(state_o), 32'(S_TERM));
      check("term_done", 32'(done_o), 32'd1);
      step();
      check("back_idle", 32'(state_o), 32'(S_IDLE));
      check("done_single", 32'(done_o), 32'd0);
      check("done_cnt_1", 32'(done_cnt), 32'd1);

      // Partial readiness holds WAIT_RDY without any req_start
      cnt_limit_i = {16'd2, 16'd0};
      exp_q.push_back(1);
      start_i = 1'b1;
      settle();
      step();
      start_i = 1'b0;
      src_ready_start_i = 2'b01;
      settle();
      for (int i = 0; i < 5; i++) begin
         check("wait_hold_state", 32'(state_o), 32'(S_WAIT));
         check("wait_hold_req", 32'({src_req_start_o, snk_req_start_o, eng_start_o}), 32'd0);
         step();
      end
      src_ready_start_i = 2'b11;
      settle();
      check("wait_rel_req", 32'({src_req_start_o, snk_req_start_o}), 32'hF);
      step();
      check("wait_rel_comp", 32'(state_o), 32'(S_COMP));
      check("wait_rel_req0", 32'({src_req_start_o, snk_req_start_o}), 32'd0);
      set_ch(1, 2);
      finish_tile(1'b1);
      step();

      // Two outputs, limits {7,3}: ch1 done at cycle 10 and keeps counting, ch0 at cycle 20
      cnt_limit_i = {16'd3, 16'd7};
      exp_q.push_back(1);
      start_job();
      for (int c = 1; c <= 20; c++) begin
         set_ch(1, (c >= 10) ? c - 7 : 0);
         set_ch(0, (c >= 20) ? 7 : c / 3);
         settle();
         check("sticky_compute", 32'(state_o), 32'(S_COMP));
         step();
      end
      check("sticky_drain", 32'(state_o), 32'(S_DRAN));
      finish_tile(1'b1);
      step();

      // Three tiles, uloop_valid arrives two cycles late each time
      cnt_limit_i = {16'd2, 16'd0};
      exp_q.push_back(3);
      start_job();
      for (int t = 0; t < 3; t++) begin
         check("tile_compute", 32'(state_o), 32'(S_COMP));
         set_ch(1, 2);
         step();
         check("tile_drain", 32'(state_o), 32'(S_DRAN));
         step();
         cnt_out_i = '0;
         settle();
         for (int d = 0; d < 2; d++) begin
            check("tile_upd_wait", 32'(state_o), 32'(S_UPD));
            check("tile_uloop_en", 32'(uloop_enable_o), 32'd1);
            step();
         end
         check("tile_cnt_upd", 32'(tile_cnt_o), 32'(t + 1));
         uloop_valid_i = 1'b1;
         uloop_done_i  = (t == 2);
         settle();
         check("tile_uloop_en0", 32'(uloop_enable_o), 32'd0);
         if (t != 2) check("tile_eng_clr", 32'(eng_clear_o), 32'd1);
         step();
         uloop_valid_i = 1'b0;
         uloop_done_i  = 1'b0;
         settle();
         if (t != 2) begin
            check("tile_rewait", 32'(state_o), 32'(S_WAIT));
            step();
         end
      end
      check("tile_term", 32'(state_o), 32'(S_TERM));
      step();
      check("tile_idle", 32'(state_o), 32'(S_IDLE));

      // Limit {0,5}: channel 0 ignored even though its counter never matches
      cnt_limit_i = {16'd5, 16'd0};
      exp_q.push_back(1);
      start_job();
      set_ch(0, 9);
      count_ch1(5);
      finish_tile(1'b1);
      step();

      // All limits zero: exactly one COMPUTE cycle
      cnt_limit_i = '0;
      exp_q.push_back(1);
      start_job();
      check("zero_comp", 32'(state_o), 32'(S_COMP));
      step();
      check("zero_drain", 32'(state_o), 32'(S_DRAN));
      finish_tile(1'b1);
      step();

      // clear_i in COMPUTE
      cnt_limit_i = {16'd3, 16'd0};
      start_job();
      check("clr_comp_pre", 32'(state_o), 32'(S_COMP));
      clear_i = 1'b1;
      settle();
      step();
      clear_i = 1'b0;
      settle();
      check("clr_comp_state", 32'(state_o), 32'(S_IDLE));
      check("clr_comp_tile", 32'(tile_cnt_o), 32'd0);

      // clear_i in UPDATEIDX: no done pulse, tile count wiped
      start_job();
      set_ch(1, 3);
      step();
      step();
      cnt_out_i = '0;
      settle();
      check("clr_upd_pre", 32'(state_o), 32'(S_UPD));
      check("clr_upd_tile1", 32'(tile_cnt_o), 32'd1);
      uloop_valid_i = 1'b1;
      uloop_done_i  = 1'b1;
      clear_i       = 1'b1;
      settle();
      check("clr_upd_nodone", 32'(done_o), 32'd0);
      step();
      clear_i       = 1'b0;
      uloop_valid_i = 1'b0;
      uloop_done_i  = 1'b0;
      settle();
      check("clr_upd_state", 32'(state_o), 32'(S_IDLE));
      check("clr_upd_tile", 32'(tile_cnt_o), 32'd0);
      step();
      check("clr_upd_stay", 32'(state_o), 32'(S_IDLE));

      // start_i while busy is ignored
      exp_q.push_back(1);
      start_job();
      start_i = 1'b1;
      settle();
      step();
      start_i = 1'b0;
      settle();
      check("busy_start_state", 32'(state_o), 32'(S_COMP));
      check("busy_start_tile", 32'(tile_cnt_o), 32'd0);
      set_ch(1, 3);
      finish_tile(1'b1);
      step();
      repeat (2) step();

      check("done_total", 32'(done_cnt), 32'd7);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("final_idle", 32'(state_o), 32'(S_IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hwpe_multistream_ctrl_fsm.md
Name: hwpe_multistream_ctrl_fsm

Overview:
- Parametrised HWPE control FSM for N_IN source streams and N_OUT sink streams.
- Supersedes the fixed 2-in/1-out per-accelerator FSMs.
- Adds multi-tile execution through uloop handshaking, per-output sticky completion tracking, a drain phase and status outputs.
- Sits between the slave/regfile, the streamer, the engine and the uloop microcode block inside each HWPE ctrl.

Parameters:
N_IN, 2, number of source (input) streams, >=1
N_OUT, 1, number of sink (output) streams, >=1
CNT_W, 32, width of each engine output counter and limit
TILE_W, 16, width of tile counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
clear_i  in  1  synchronous clear, forces IDLE
start_i  in  1  job start pulse from slave
src_ready_start_i  in  N_IN  per-source ready_start flags
snk_ready_start_i  in  N_OUT  per-sink ready_start flags
src_req_start_o  out  N_IN  per-source req_start
snk_req_start_o  out  N_OUT  per-sink req_start
eng_start_o  out  1  engine trigger
eng_clear_o  out  1  engine counter clear
eng_enable_o  out  1  engine enable
eng_ready_i  in  1  engine ready for retrigger
cnt_out_i  in  N_OUT*CNT_W  packed engine output counters, channel k at [k*CNT_W +: CNT_W]
cnt_limit_i  in  N_OUT*CNT_W  packed per-output limits; 0 = channel unused
uloop_enable_o  out  1  request uloop offset update
uloop_clear_o  out  1  uloop clear
uloop_valid_i  in  1  uloop offsets valid
uloop_done_i  in  1  uloop finished all iterations
done_o  out  1  job done pulse to slave
busy_o  out  1  high in any state except IDLE
tile_cnt_o  out  TILE_W  tiles completed in current job
state_o  out  3  encoded current state for debug

Behaviour:
- Reset is asynchronous, active-low on rst_ni; clock is clk_i.
- Reset/clear state: IDLE, tile_cnt_o=0, sticky out_done flags=0.
- clear_i has priority over all transitions.
- Output defaults (all states unless overridden): req_start=0, eng_start=0, eng_clear=1, eng_enable=1, uloop_enable=0, uloop_clear=0, done=0.
- State encoding: IDLE=0, WAIT_RDY=1, COMPUTE=2, DRAIN=3, UPDATEIDX=4, TERMINATE=5.
- IDLE:
  - uloop_clear=1.
  - start_i -> WAIT_RDY; tile_cnt cleared; out_done[k] preloaded to (cnt_limit_i[k]==0).
- WAIT_RDY:
  - eng_clear=0, eng_enable=0.
  - all_rdy = AND of src_ready_start_i and snk_ready_start_i.
  - If all_rdy, in the same cycle: all req_start bits=1, eng_start=1, eng_enable=1 (one cycle) -> COMPUTE. Otherwise stay.
- COMPUTE:
  - eng_clear=0, eng_enable=1.
  - out_done[k] is set (sticky) when cnt_out_i[k]==cnt_limit_i[k].
  - eng_start=eng_ready_i.
  - If all out_done are set, or become set this cycle -> DRAIN.
  - If every limit is 0: one COMPUTE cycle, then DRAIN.
- DRAIN:
  - eng_clear=0, eng_enable=0.
  - Wait for all_rdy -> UPDATEIDX; tile_cnt increments on that transition, wrapping at 2^TILE_W.
- UPDATEIDX:
  - eng_clear=0, eng_enable=0, uloop_enable=~uloop_valid_i.
  - If uloop_valid_i & uloop_done_i -> TERMINATE.
  - If uloop_valid_i & ~uloop_done_i -> WAIT_RDY, with out_done re-preloaded from limits and engine counters cleared (eng_clear=1 that cycle).
- TERMINATE:
  - done_o=1 for exactly one cycle -> IDLE.
- start_i outside IDLE is ignored; no queuing.
- req_start bits are never asserted unless all_rdy is high in the same cycle.
- Minimum latency from start_i (cycle 0) with all flags ready: req_start/eng_start in cycle 1, COMPUTE in cycle 2.
- busy_o is registered from the state, so it is 0 in the cycle start_i is accepted.

Test Plan:
- N_IN=2, N_OUT=1, limit=4, all ready, uloop_done on first valid -> req_start 2'b11/1'b1 in cycle 1; DRAIN after cnt_out reaches 4; done_o single pulse; tile_cnt_o=1; back to IDLE.
- src_ready_start_i=2'b01 held 5 cycles after start -> FSM stays WAIT_RDY, req_start stays 0; on 2'b11 -> one-cycle req_start, then COMPUTE.
- N_OUT=2, limits {7,3}; counter 1 hits 3 at cycle 10, counter 0 hits 7 at cycle 20 (counter 1 then runs past 3) -> DRAIN only after cycle 20, sticky flag retained.
- 3 tiles: uloop_done asserted on the third valid; uloop_valid delayed 2 cycles each time -> uloop_enable high until valid; tile_cnt_o=3; exactly one done_o.
- Limit {0,5} -> channel 0 ignored, DRAIN after channel 1 reaches 5; all limits 0 -> DRAIN after one COMPUTE cycle.
- clear_i in COMPUTE and in UPDATEIDX -> IDLE next cycle, tile_cnt_o=0, no done_o; start_i while busy -> no effect.
